serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Parallel-to-serial front end for the sequence-detector chain. It accepts WIDTH-bit words over a valid/ready handshake, buffers up to two words (one shifting, one held), and emits one bit per clock on a serial output. That output drives the detector's serial `data_in` directly, with a qualifying bit-valid strobe. Back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width in bits, minimum 2.
- `MSB_FIRST`, default 1'b1: 1'b1 shifts bit WIDTH-1 first; 1'b0 shifts bit 0 first.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `din`  in  WIDTH: parallel word.
- `din_valid`  in  1: `din` is valid this cycle.
- `din_ready`  out  1: the block can accept a word this cycle.
- `data_out`  out  1: serial bit; feeds the detector's `data_in`.
- `bit_valid`  out  1: `data_out` carries a word bit this cycle.
- `word_done`  out  1: the bit currently on `data_out` is the last bit of its word.

## Operation
- Storage: one shift register plus bit counter, and one holding register with a `hold_full` flag.
- States:
  - IDLE: shifter empty.
  - SHIFT: data bits going out.
  - PARITY: exists only with the macro enabled.
- Acceptance: a word is accepted on an edge where `din_valid && din_ready`.
- `din_ready` = `!hold_full && !rst`; it is combinational from registered state.
- Routing of an accepted word:
  - IDLE, or the shifter is on its final bit this edge with `hold_full`=0: load directly into the shifter and enter SHIFT.
  - Otherwise: write into the holding register and set `hold_full`.
- Final-bit edge:
  - `hold_full`=1: the holding word moves into the shifter and `hold_full` clears.
  - Else a word accepted on the same edge loads directly.
  - Else go to IDLE.
- Hold full while shifting: `din_ready`=0, so there is no third-word case.
- `bit_valid`=1 in SHIFT and PARITY, 0 in IDLE.
- `data_out`=0 in IDLE.
- `word_done`=1 exactly on the last bit cycle of each word.
- Bit counter counts 0..WIDTH-1 and wraps on the final bit.
- Reset mid-word: shifter and holding contents are discarded. No `word_done` is produced for the aborted word.

## Timing
- Reset values:
  - `data_out`=0, `bit_valid`=0, `word_done`=0.
  - `din_ready`=0 while `rst` is high, then 1 in the first cycle after release.
  - State IDLE, `hold_full`=0, counter 0.
- Latency: first bit appears on `data_out` in the cycle after the accepting edge.
- Word duration: WIDTH cycles, or WIDTH+1 with parity.
- Streaming: continuous `bit_valid` across words whenever the next word is accepted no later than the final-bit edge of the current one.
- Outputs are registered and change only on `clk` edges or on `rst` assertion.

## Configuration
- Macro: `SERIAL_FEEDER_PARITY_EN`.
- Defined:
  - After the last data bit, the block enters PARITY for one cycle.
  - It outputs the odd-parity bit (`~^word`), so ones across data plus parity is odd.
  - `word_done` moves to the parity cycle.
  - The holding word transfers on the parity edge.
- Undefined: no PARITY state; words are exactly WIDTH bits.

## Structure
- Shared package `serial_pkg`:
  - state enum typedef (IDLE/SHIFT/PARITY).
  - default WIDTH constant.
  - counter-width function `$clog2(WIDTH)`.
- One natural sub-module: `word_hold_buf`, the single-entry holding register with its full flag, load/unload strobes and ready generation.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, `din`=8'h92:
  - `data_out` = 1,0,0,1,0,0,1,0 on the 8 cycles after acceptance.
  - `bit_valid` high for those 8 cycles; `word_done` on the 8th only.
  - Back to IDLE with `data_out`=0.
- Back-to-back 8'hA5 then 8'h3C, both presented immediately:
  - 16 contiguous `bit_valid` cycles.
  - Serial stream 10100101 00111100.
  - `word_done` on cycles 8 and 16.
- Backpressure: `din_valid` held with three words while the first shifts:
  - `din_ready` falls after the second is accepted.
  - It returns to 1 after the first word's final-bit edge; the third is accepted then.
  - No word is lost or duplicated.
- MSB_FIRST=0, `din`=8'h01: stream is 1 followed by seven 0s.
- With `SERIAL_FEEDER_PARITY_EN`:
  - 8'h92 gives 9 bits ending in parity 0.
  - 8'h93 gives parity 1.
  - `word_done` on the 9th cycle each.
- Reset mid-word: assert `rst` after the 3rd bit of 8'hFF.
  - `data_out`/`bit_valid`/`word_done` drop to 0 asynchronously.
  - After release, `din_ready`=1, and a new word 8'h92 serialises from its first bit.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word feeder.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// Single-entry holding register for the feeder; the full flag gates din_ready.
module word_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // load needs ready (empty) and unload needs full, so they never coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_ready = !r_full && !rst;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: buffers up to two words and streams one bit per clock.
// Optional odd-parity trailer bit when SERIAL_FEEDER_PARITY_EN is defined.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_done
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state, w_nxt_state;
    logic [WIDTH-1:0] r_shift, w_nxt_shift, w_shifted, w_hold_data, w_load_word;
    logic [CW-1:0]    r_cnt, w_nxt_cnt;
    logic             r_data_out, r_bit_valid, r_word_done;
    logic             w_nxt_data, w_nxt_done;
    logic             w_acc, w_word_end, w_direct, w_hold_wr, w_hold_rd;
    logic             w_hold_full, w_ready, w_load;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             r_par, w_nxt_par;
`endif

    word_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_hold_wr),
        .i_unload (w_hold_rd),
        .i_data   (din),
        .o_data   (w_hold_data),
        .o_full   (w_hold_full),
        .o_ready  (w_ready)
    );

    assign din_ready = w_ready;
    assign w_acc     = din_valid && w_ready;

`ifdef SERIAL_FEEDER_PARITY_EN
    assign w_word_end = (r_state == ST_PARITY);
`else
    assign w_word_end = (r_state == ST_SHIFT) && (r_cnt == LAST);
`endif

    // An accepted word bypasses the holding register only when the shifter frees up this edge
    assign w_direct    = (r_state == ST_IDLE) || (w_word_end && !w_hold_full);
    assign w_hold_wr   = w_acc && !w_direct;
    assign w_hold_rd   = w_word_end && w_hold_full;
    assign w_load      = w_hold_rd || (w_acc && w_direct);
    assign w_load_word = w_hold_rd ? w_hold_data : din;
    assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_shift = r_shift;
        w_nxt_cnt   = r_cnt;
`ifdef SERIAL_FEEDER_PARITY_EN
        w_nxt_par   = r_par;
`endif
        case (r_state)
            ST_SHIFT: begin
                w_nxt_shift = w_shifted;
                w_nxt_cnt   = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_nxt_cnt = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
                    w_nxt_state = ST_PARITY;
`else
                    w_nxt_state = ST_IDLE;
`endif
                end
            end
            ST_PARITY: w_nxt_state = ST_IDLE;
            default: ;
        endcase
        if (w_load) begin
            w_nxt_shift = w_load_word;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
            w_nxt_par   = ~^w_load_word;
`endif
        end
    end

    always_comb begin
        w_nxt_data = 1'b0;
        case (w_nxt_state)
            ST_SHIFT:  w_nxt_data = MSB_FIRST ? w_nxt_shift[WIDTH-1] : w_nxt_shift[0];
`ifdef SERIAL_FEEDER_PARITY_EN
            ST_PARITY: w_nxt_data = w_nxt_par;
`endif
            default:   w_nxt_data = 1'b0;
        endcase
`ifdef SERIAL_FEEDER_PARITY_EN
        w_nxt_done = (w_nxt_state == ST_PARITY);
`else
        w_nxt_done = (w_nxt_state == ST_SHIFT) && (w_nxt_cnt == LAST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data_out  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_shift     <= w_nxt_shift;
            r_cnt       <= w_nxt_cnt;
            r_data_out  <= w_nxt_data;
            r_bit_valid <= (w_nxt_state != ST_IDLE);
            r_word_done <= w_nxt_done;
        end
    end

`ifdef SERIAL_FEEDER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_par <= 1'b0;
        else     r_par <= w_nxt_par;
    end
`endif

    assign data_out  = r_data_out;
    assign bit_valid = r_bit_valid;
    assign word_done = r_word_done;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (MSB-first and LSB-first instances).
module tb_serial_word_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int WL = 9;
`else
    localparam int WL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1;
    logic       v0, v1, rdy0, rdy1, do0, do1, bv0, bv1, wd0, wd1;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
        .data_out(do0), .bit_valid(bv0), .word_done(wd0)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .data_out(do1), .bit_valid(bv1), .word_done(wd1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ~^w;
        return msb ? w[7-i] : w[i];
    endfunction

    // checks bit i of word w on the MSB-first instance
    task automatic chk_bit0(input string tag, input logic [7:0] w, input int i);
        chk($sformatf("%s_b%0d_data", tag, i), do0, exp_bit(w, i, 1'b1));
        chk($sformatf("%s_b%0d_bv", tag, i), bv0, 1'b1);
        chk($sformatf("%s_b%0d_wd", tag, i), wd0, (i == WL - 1));
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_idle_data"}, do0, 1'b0);
        chk({tag, "_idle_bv"}, bv0, 1'b0);
        chk({tag, "_idle_wd"}, wd0, 1'b0);
    endtask

    task automatic single_word(input string tag, input logic [7:0] w);
        din0 = w;
        v0   = 1'b1;
        chk({tag, "_ready"}, rdy0, 1'b1);
        tick();
        v0 = 1'b0;
        for (int i = 0; i < WL; i++) begin
            chk_bit0(tag, w, i);
            tick();
        end
        chk_idle0(tag);
    endtask

    initial begin
        logic [7:0] bb [2];
        logic [7:0] bp [3];
        rst = 1'b1; din0 = '0; din1 = '0; v0 = 1'b0; v1 = 1'b0;

        #3;
        chk("rst_data", do0, 1'b0);
        chk("rst_bv", bv0, 1'b0);
        chk("rst_wd", wd0, 1'b0);
        chk("rst_ready0", rdy0, 1'b0);
        chk("rst_ready1", rdy1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rdy0, 1'b1);
        chk("post_rst_bv", bv0, 1'b0);

        single_word("w92", 8'h92);
        single_word("w93", 8'h93);

        // back-to-back: second word offered while the first is still on its first bit
        bb[0] = 8'hA5; bb[1] = 8'h3C;
        din0 = bb[0]; v0 = 1'b1;
        tick();
        for (int c = 0; c < 2 * WL; c++) begin
            chk_bit0("b2b", bb[c / WL], c % WL);
            if (c == 0) begin
                din0 = bb[1];
                chk("b2b_ready_c0", rdy0, 1'b1);
            end
            if (c == 1) v0 = 1'b0;
            tick();
        end
        chk_idle0("b2b");

        // backpressure: three words offered with din_valid held
        bp[0] = 8'hC3; bp[1] = 8'h5A; bp[2] = 8'hE1;
        din0 = bp[0]; v0 = 1'b1;
        chk("bp_ready_pre", rdy0, 1'b1);
        tick();
        for (int c = 0; c < 3 * WL; c++) begin
            chk_bit0("bp", bp[c / WL], c % WL);
            if (c == 0) begin
                chk("bp_ready_c0", rdy0, 1'b1);
                din0 = bp[1];
            end
            if (c == 1) begin
                chk("bp_ready_c1", rdy0, 1'b0);
                din0 = bp[2];
            end
            if (c == WL - 1) chk("bp_ready_last", rdy0, 1'b0);
            if (c == WL)     chk("bp_ready_back", rdy0, 1'b1);
            if (c == WL + 1) begin
                chk("bp_ready_full", rdy0, 1'b0);
                v0 = 1'b0;
            end
            tick();
        end
        chk_idle0("bp");

        // LSB-first instance
        din1 = 8'h01; v1 = 1'b1;
        chk("lsb_ready", rdy1, 1'b1);
        tick();
        v1 = 1'b0;
        for (int i = 0; i < WL; i++) begin
            chk($sformatf("lsb_b%0d_data", i), do1, exp_bit(8'h01, i, 1'b0));
            chk($sformatf("lsb_b%0d_bv", i), bv1, 1'b1);
            chk($sformatf("lsb_b%0d_wd", i), wd1, (i == WL - 1));
            tick();
        end
        chk("lsb_idle_bv", bv1, 1'b0);
        chk("lsb_idle_data", do1, 1'b0);

        // reset in the middle of a word
        din0 = 8'hFF; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_bit0("rmw", 8'hFF, i);
            tick();
        end
        chk("rmw_pre_data", do0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmw_async_data", do0, 1'b0);
        chk("rmw_async_bv", bv0, 1'b0);
        chk("rmw_async_wd", wd0, 1'b0);
        chk("rmw_async_ready", rdy0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rmw_rel_ready", rdy0, 1'b1);
        chk("rmw_rel_bv", bv0, 1'b0);
        single_word("rmw92", 8'h92);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
